dot_product_mac_ctrl: RTL and testbench
=======================================

DOT_PRODUCT_MAC_CTRL -- requirements
Module: dot_product_mac_ctrl

Interface
REQ-001 Parameter DIN0_WIDTH, default 32: width of operand A and of multiplier port din0.
REQ-002 Parameter DIN1_WIDTH, default 39: width of operand B and of multiplier port din1.
REQ-003 Parameter PROD_WIDTH, default 71: width of multiplier product (DIN0_WIDTH+DIN1_WIDTH).
REQ-004 Parameter LEN_WIDTH, default 8: width of vector length; max length 2^LEN_WIDTH-1.
REQ-005 Parameter ACC_WIDTH, default PROD_WIDTH+LEN_WIDTH: accumulator/result width.
REQ-006 Port clk input 1: single clock, all state on rising edge.
REQ-007 Port reset input 1: one clock; reset is asynchronous and active-low.
REQ-008 Port start input 1 / start_ready output 1: job request handshake; accepted when both high.
REQ-009 Port len input LEN_WIDTH: element count, sampled on start acceptance.
REQ-010 Port abort input 1: synchronous job cancel.
REQ-011 Port in_valid input 1 / in_ready output 1: element handshake; transfer when both high.
REQ-012 Port in_a input DIN0_WIDTH / in_b input DIN1_WIDTH: unsigned operand pair.
REQ-013 Port mul_ce output 1, mul_din0 output DIN0_WIDTH, mul_din1 output DIN1_WIDTH: drive to shared 1-register-stage unsigned multiplier.
REQ-014 Port mul_dout input PROD_WIDTH: multiplier result, valid 1 cycle after the ce-qualified edge sampling its operands.
REQ-015 Port result output ACC_WIDTH / result_valid output 1 / result_ready input 1: dot-product result handshake.
REQ-016 Port busy output 1: high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 start_ready SHALL equal (state==IDLE); start outside IDLE is ignored.
REQ-019 IDLE, start accepted, len!=0: clear accumulator and element counter, latch len, go RUN.
REQ-020 IDLE, start accepted, len==0: clear accumulator, go DONE directly (result 0).
REQ-021 in_ready SHALL equal (state==RUN); in_valid stalls permitted any cycle without loss.
REQ-022 mul_din0/mul_din1 SHALL be in_a/in_b combinationally; mul_ce SHALL be high in RUN and DRAIN, low otherwise.
REQ-023 A registered flag p_valid SHALL be set on each edge with an element transfer and cleared on edges without one.
REQ-024 On each edge with p_valid high, accumulator SHALL add zero-extended mul_dout; unsigned, no saturation, overflow impossible by width rule.
REQ-025 Transfer of element number len (counter==len-1) SHALL move RUN->DRAIN.
REQ-026 DRAIN SHALL last exactly one cycle, performing the final accumulate, then go DONE.
REQ-027 In DONE result_valid SHALL be high and result SHALL hold the accumulator stable until result_ready.
REQ-028 DONE with result_ready high SHALL return to IDLE; a start in that same cycle is ignored.
REQ-029 Latency: result_valid rises 2 cycles after the edge transferring the last element.
REQ-030 abort high in RUN, DRAIN or DONE SHALL go IDLE next edge, clear p_valid and counter, no result_valid; abort in IDLE has no effect; abort overrides all other events.
REQ-031 Throughput: one element per cycle while in_valid held high.

Reset
REQ-032 reset low SHALL immediately force state IDLE; accumulator, counter, latched len, p_valid, result all zero.
REQ-033 During/after reset: start_ready=1, in_ready=0, mul_ce=0, result_valid=0, busy=0.
REQ-034 Reset asserted mid-job SHALL discard the job; no result_valid after release.

Verification
REQ-035 len=3, pairs (1,2),(3,4),(5,6) back-to-back -> result=44, result_valid 2 cycles after third transfer.
REQ-036 len=2, pairs (0xFFFFFFFF,0x7FFFFFFFFF)x2 with 2-cycle in_valid gap -> result=2*(2^32-1)*(2^39-1), no lost/duplicated element.
REQ-037 len=0 start -> DONE next cycle, result=0, in_ready never high.
REQ-038 result_ready held low 5 cycles in DONE with start pulsed -> result stable, start ignored, IDLE after result_ready.
REQ-039 len=4, abort after 2 transfers -> IDLE next edge, no result_valid; next job len=1 (7,3) -> result=21.
REQ-040 reset low during RUN after 1 transfer -> all outputs at reset values immediately; new job len=1 (2,5) -> result=10.

Source files
------------

// File: rtl/dot_product_mac_ctrl.sv
// Dot-product job controller: streams operand pairs into a shared one-stage
// multiplier and accumulates the products, returning the sum with a handshake.
module dot_product_mac_ctrl #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 39,
  parameter int PROD_WIDTH = 71,
  parameter int LEN_WIDTH  = 8,
  parameter int ACC_WIDTH  = PROD_WIDTH + LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,        // active-low, asynchronous
  input  logic                  start,
  output logic                  start_ready,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] in_a,
  input  logic [DIN1_WIDTH-1:0] in_b,
  output logic                  mul_ce,
  output logic [DIN0_WIDTH-1:0] mul_din0,
  output logic [DIN1_WIDTH-1:0] mul_din1,
  input  logic [PROD_WIDTH-1:0] mul_dout,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, nxt;
  logic [LEN_WIDTH-1:0] cnt, len_q, cnt_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 p_valid;
  logic                 xfer, start_acc, abort_any;

  assign xfer      = (state == RUN) && in_valid;
  assign start_acc = (state == IDLE) && start;
  assign abort_any = (state != IDLE) && abort;
  assign cnt_nxt   = cnt + LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt          = state;
    start_ready  = 1'b0;
    in_ready     = 1'b0;
    mul_ce       = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start) nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        mul_ce   = 1'b1;
        if (xfer && cnt_nxt == len_q) nxt = DRAIN;
      end
      DRAIN: begin
        mul_ce = 1'b1;
        nxt    = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // abort wins over every other transition
    if (abort_any) begin
      nxt          = IDLE;
      result_valid = 1'b0;
    end
  end

  // p_valid tracks the product currently on mul_dout (one edge behind the transfer)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid <= 1'b0;
      cnt     <= '0;
      len_q   <= '0;
      acc     <= '0;
    end else begin
      p_valid <= xfer && !abort_any;
      if (start_acc) begin
        cnt   <= '0;
        len_q <= len;
        acc   <= '0;
      end else if (abort_any) begin
        cnt <= '0;
      end else begin
        if (xfer)    cnt <= cnt_nxt;
        if (p_valid) acc <= acc + ACC_WIDTH'(mul_dout);
      end
    end
  end

  assign mul_din0 = in_a;
  assign mul_din1 = in_b;
  assign result   = acc;

endmodule

// File: tb/tb_dot_product_mac_ctrl.sv
// Directed bench for dot_product_mac_ctrl: vector table of whole jobs plus
// hand-written sequences for zero length, held result, abort and mid-job reset.
module tb_dot_product_mac_ctrl;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0, abort = 1'b0, in_valid = 1'b0, result_ready = 1'b0;
  logic [7:0]            len = '0;
  logic [31:0]           in_a = '0;
  logic [38:0]           in_b = '0;
  logic                  start_ready, in_ready, mul_ce, result_valid, busy;
  logic [31:0]           mul_din0;
  logic [38:0]           mul_din1;
  logic [70:0]           mul_dout = '0;
  logic [78:0]           result;

  int checks = 0;
  int passed = 0;

  dot_product_mac_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(start_ready), .len(len),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .result(result), .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // shared one-register-stage unsigned multiplier
  always_ff @(posedge clk)
    if (mul_ce) mul_dout <= {39'd0, mul_din0} * {32'd0, mul_din1};

  typedef struct {
    int                len;
    logic [3:0][31:0]  a;
    logic [3:0][38:0]  b;
    int                gap;
    logic [78:0]       exp;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [78:0] act, input logic [78:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // runs a job with len>0 and stops in DONE with the result checked
  task automatic job(input string nm, input int l, input logic [3:0][31:0] a,
                     input logic [3:0][38:0] b, input int gap, input logic [78:0] exp);
    chk({nm, "_start_ready"}, 79'(start_ready), 79'd1);
    start = 1'b1;
    len   = 8'(l);
    tick();
    start = 1'b0;
    for (int i = 0; i < l; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_a     = 32'd5;
          in_b     = 39'd9;
          tick();
        end
      end
      in_valid = 1'b1;
      in_a     = a[i];
      in_b     = b[i];
      chk($sformatf("%s_in_ready%0d", nm, i), 79'(in_ready), 79'd1);
      tick();
    end
    in_valid = 1'b0;
    chk({nm, "_drain_no_valid"}, 79'(result_valid), 79'd0);
    tick();
    chk({nm, "_valid_lat2"}, 79'(result_valid), 79'd1);
    chk({nm, "_result"}, result, exp);
  endtask

  task automatic release_result(input string nm);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({nm, "_idle_after_ready"}, 79'(busy), 79'd0);
  endtask

  initial begin
    vecs[0] = '{len: 3, a: {32'd0, 32'd5, 32'd3, 32'd1}, b: {39'd0, 39'd6, 39'd4, 39'd2},
                gap: 0, exp: 79'd44};
    vecs[1] = '{len: 2, a: {32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                b: {39'd0, 39'd0, 39'h7FFFFFFFFF, 39'h7FFFFFFFFF}, gap: 2,
                exp: (79'd1 << 72) - (79'd1 << 40) - (79'd1 << 33) + 79'd2};
    vecs[2] = '{len: 1, a: {32'd0, 32'd0, 32'd0, 32'd7}, b: {39'd0, 39'd0, 39'd0, 39'd3},
                gap: 0, exp: 79'd21};
    vecs[3] = '{len: 4, a: {32'd1, 32'd0, 32'd20, 32'd10}, b: {39'd1, 39'd99, 39'd1, 39'd10},
                gap: 1, exp: 79'd121};

    #2;
    chk("rst_start_ready", 79'(start_ready), 79'd1);
    chk("rst_in_ready", 79'(in_ready), 79'd0);
    chk("rst_mul_ce", 79'(mul_ce), 79'd0);
    chk("rst_result_valid", 79'(result_valid), 79'd0);
    chk("rst_busy", 79'(busy), 79'd0);
    chk("rst_result", result, 79'd0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      job($sformatf("vec%0d", i), vecs[i].len, vecs[i].a, vecs[i].b, vecs[i].gap, vecs[i].exp);
      release_result($sformatf("vec%0d", i));
    end

    // zero-length job goes straight to DONE with result 0
    start = 1'b1;
    len   = 8'd0;
    chk("len0_in_ready_idle", 79'(in_ready), 79'd0);
    tick();
    start = 1'b0;
    chk("len0_valid", 79'(result_valid), 79'd1);
    chk("len0_result", result, 79'd0);
    chk("len0_in_ready_done", 79'(in_ready), 79'd0);
    release_result("len0");

    // result held while result_ready low; start ignored in DONE and on exit
    job("hold", 1, {32'd0, 32'd0, 32'd0, 32'd2}, {39'd0, 39'd0, 39'd0, 39'd3}, 0, 79'd6);
    start = 1'b1;
    len   = 8'd1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold_result%0d", c), result, 79'd6);
      chk($sformatf("hold_valid%0d", c), 79'(result_valid), 79'd1);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    chk("hold_start_ignored", 79'(busy), 79'd0);
    tick();
    chk("hold_still_idle", 79'(busy), 79'd0);

    // abort after two transfers, then a fresh job
    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(i + 1);
      in_b     = 39'd1;
      tick();
    end
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_idle", 79'(busy), 79'd0);
    chk("abort_start_ready", 79'(start_ready), 79'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort_no_valid%0d", c), 79'(result_valid), 79'd0);
      tick();
    end
    job("post_abort", 1, {32'd0, 32'd0, 32'd0, 32'd7}, {39'd0, 39'd0, 39'd0, 39'd3}, 0, 79'd21);
    release_result("post_abort");

    // asynchronous reset mid-job
    start = 1'b1;
    len   = 8'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 32'd4;
    in_b     = 39'd4;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_start_ready", 79'(start_ready), 79'd1);
    chk("mrst_in_ready", 79'(in_ready), 79'd0);
    chk("mrst_mul_ce", 79'(mul_ce), 79'd0);
    chk("mrst_busy", 79'(busy), 79'd0);
    chk("mrst_result", result, 79'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mrst_no_valid%0d", c), 79'(result_valid), 79'd0);
    end
    job("post_rst", 1, {32'd0, 32'd0, 32'd0, 32'd2}, {39'd0, 39'd0, 39'd0, 39'd5}, 0, 79'd10);
    release_result("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
